// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared state encoding, limits and address range helper for ram_ctrl
package ram_ctrl_pkg;
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
  localparam int RD_LAT_MAX = 2;
  function automatic logic in_range(input logic [31:0] addr, input int depth);
    return addr < 32'(depth);
  endfunction
endpackage

// File: rtl/ram_ctrl_rdpipe.sv
// ram_ctrl_rdpipe: LAT-deep valid/data shift pipeline whose data holds when no valid moves through
module ram_ctrl_rdpipe
  import ram_ctrl_pkg::*;
#(
  parameter int W   = 9,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [LAT-1:0] v;
  logic [W-1:0]   d [LAT];
  // advance valid every cycle, move data only alongside a valid so the output holds
  always_ff @(posedge clk) begin
    if (clr) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end
  assign out_valid = v[LAT-1];
  assign out_data  = d[LAT-1];
endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port RAM with valid/ready requests, pipelined reads, clear sweep and low-word debug mirror
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int DEPTH   = 256,
  parameter int A_WIDTH = $clog2(DEPTH),
  parameter int RD_LAT  = 1,
  parameter int N_DBG   = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     soft_clr,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [A_WIDTH-1:0]       req_addr,
  input  logic [D_WIDTH-1:0]       req_wdata,
  output logic                     rsp_valid,
  output logic [D_WIDTH-1:0]       rsp_rdata,
  output logic                     rsp_err,
  output logic                     wr_err,
  output logic                     busy,
  output logic [N_DBG*D_WIDTH-1:0] dbg_words
);
  localparam logic [A_WIDTH-1:0] LAST = A_WIDTH'(DEPTH - 1);
  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("ram_ctrl: RD_LAT must be 1 or 2");
  end
  state_t             state;
  logic [A_WIDTH-1:0] ptr;
  logic [D_WIDTH-1:0] mem [DEPTH];
  logic               acc, in_rng, wr_acc, rd_acc, p_valid;
  logic [D_WIDTH:0]   rd_word, p_data;
  assign busy      = state == ST_CLEAR;
  assign req_ready = state == ST_IDLE && !soft_clr;
  assign acc       = req_valid && req_ready;
  assign in_rng    = in_range(32'(req_addr), DEPTH);
  assign wr_acc    = acc && req_we;
  assign rd_acc    = acc && !req_we;
  assign rd_word   = in_rng ? {1'b0, mem[req_addr]} : {1'b1, {D_WIDTH{1'b0}}};
  // sweep sequencing, soft-clear entry and write-error flag
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= ST_CLEAR;
      ptr    <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_acc && !in_rng;
      if (state == ST_CLEAR) begin
        ptr   <= ptr == LAST ? '0 : ptr + A_WIDTH'(1);
        state <= ptr == LAST ? ST_IDLE : ST_CLEAR;
      end else if (soft_clr) begin
        state <= ST_CLEAR;
        ptr   <= '0;
      end
    end
  end
  // storage: sweep zeroes one word per cycle, otherwise in-range writes land at the accepting edge
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (state == ST_CLEAR) mem[ptr] <= '0;
      else if (wr_acc && in_rng) mem[req_addr] <= req_wdata;
    end
  end
  // low-word mirror, zeroed as soon as any sweep starts so it reads zero throughout
  always_ff @(posedge clk) begin
    if (clr || (state == ST_IDLE && soft_clr)) dbg_words <= '0;
    else for (int i = 0; i < N_DBG; i++)
      if (wr_acc && 32'(req_addr) == 32'(i)) dbg_words[i*D_WIDTH +: D_WIDTH] <= req_wdata;
  end
  ram_ctrl_rdpipe #(.W(D_WIDTH + 1), .LAT(RD_LAT)) u_rdpipe (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .out_valid (p_valid),
    .out_data  (p_data)
  );
  assign rsp_valid = p_valid;
  assign rsp_err   = p_valid && p_data[D_WIDTH];
  assign rsp_rdata = p_data[D_WIDTH-1:0];
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed stimulus with a read-response scoreboard for ram_ctrl
module tb_ram_ctrl;
  localparam int DW = 8, DEPTH = 200, AW = 8, RD_LAT = 2, N_DBG = 8;
  typedef struct {
    int          due;
    logic        err;
    logic [DW-1:0] data;
  } exp_t;
  logic clk = 0, clr = 0, soft_clr = 0, req_valid = 0, req_we = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, wr_err, busy;
  logic [DW-1:0] rsp_rdata;
  logic [N_DBG*DW-1:0] dbg_words;
  int cyc = 0, n_checks = 0, n_fail = 0;
  logic [DW-1:0] model [DEPTH];
  exp_t sb[$];

  ram_ctrl #(.D_WIDTH(DW), .DEPTH(DEPTH), .A_WIDTH(AW), .RD_LAT(RD_LAT), .N_DBG(N_DBG)) dut (
    .clk(clk), .clr(clr), .soft_clr(soft_clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .wr_err(wr_err), .busy(busy), .dbg_words(dbg_words)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic chk_dbg(input string tag);
    logic [63:0] e = '0;
    for (int i = 0; i < N_DBG; i++) e[i*DW +: DW] = model[i];
    check(tag, 64'(dbg_words), e);
  endtask

  task automatic rd(input int a);
    exp_t e;
    req_valid = 1; req_we = 0; req_addr = AW'(a);
    #1 check("rd_ready", req_ready, 1);
    e.due = cyc + RD_LAT;
    e.err = a >= DEPTH;
    e.data = '0;
    if (a < DEPTH) e.data = model[a];
    sb.push_back(e);
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    req_valid = 1; req_we = 1; req_addr = AW'(a); req_wdata = d;
    #1 check("wr_ready", req_ready, 1);
    if (a < DEPTH) model[a] = d;
    @(negedge clk);
    req_valid = 0;
    check("wr_err", wr_err, a >= DEPTH);
  endtask

  task automatic wait_sweep(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 4 * DEPTH) begin
      @(negedge clk);
      n++;
    end
    check(tag, n, DEPTH);
    check("ready_after_sweep", req_ready, 1);
  endtask

  always @(negedge clk) begin
    logic ev;
    exp_t e;
    ev = sb.size() > 0 && sb[0].due == cyc;
    if (rsp_valid === 1'b1 || ev) begin
      check("rsp_valid", rsp_valid, ev);
      if (ev) begin
        e = sb.pop_front();
        if (rsp_valid === 1'b1) begin
          check("rsp_err", rsp_err, e.err);
          check("rsp_rdata", rsp_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    clr = 1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_dbg", dbg_words, 0);
    clr = 0;
    zero_model();
    wait_sweep("sweep_len");
    for (int a = 0; a < DEPTH; a++) rd(a);
    wr(3, 8'hA5);
    rd(3);
    check("dbg_word3", dbg_words[31:24], 8'hA5);
    chk_dbg("dbg_after_w3");
    wr(16, 8'h01); wr(17, 8'h02); wr(18, 8'h03);
    rd(16); rd(17); rd(18);
    wr(200, 8'h77);
    @(negedge clk);
    check("wr_err_pulse", wr_err, 0);
    chk_dbg("dbg_after_oor");
    rd(200);
    wr(255, 8'h66);
    rd(255);
    rd(3);
    wr(32, 8'h11); wr(33, 8'h22);
    rd(32); rd(33);
    req_valid = 1; req_we = 0; req_addr = 8'd34; soft_clr = 1;
    #1 check("soft_clr_ready", req_ready, 0);
    @(negedge clk);
    soft_clr = 0; req_valid = 0;
    zero_model();
    check("soft_clr_busy", busy, 1);
    chk_dbg("dbg_in_sweep");
    repeat (49) @(negedge clk);
    check("mid_sweep_busy", busy, 1);
    check("mid_sweep_ready", req_ready, 0);
    clr = 1;
    @(negedge clk);
    clr = 0;
    wait_sweep("sweep_restart_len");
    for (int a = 0; a < DEPTH; a++) rd(a);
    chk_dbg("dbg_after_restart");
    soft_clr = 1;
    @(negedge clk);
    soft_clr = 0;
    req_valid = 1; req_we = 1; req_addr = 8'd0; req_wdata = 8'h5A;
    begin
      int n = 0;
      while (req_ready !== 1'b1 && n < 4 * DEPTH) begin
        @(negedge clk);
        n++;
      end
      check("stall_len", n, DEPTH);
    end
    @(negedge clk);
    req_valid = 0;
    model[0] = 8'h5A;
    check("stall_wr_err", wr_err, 0);
    rd(0); rd(1);
    chk_dbg("dbg_after_stall");
    repeat (RD_LAT + 2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Parametrised single-port synchronous RAM with a valid/ready request channel, a registered response channel and a multi-cycle clear engine.
- Successor to the 8x256 memory used by the accumulator processor. Adds configurable width and depth, read latency of 1 or 2, out-of-range detection, a soft-clear command and a debug window onto the low words.
- Sits between the processor/cache controller and storage.

Parameters:
- D_WIDTH, 8, data word width in bits (>=1).
- DEPTH, 256, number of words (>=2, need not be a power of two).
- A_WIDTH, $clog2(DEPTH), address width.
- RD_LAT, 1, read latency in cycles (1 or 2 only; other values are an elaboration error).
- N_DBG, 8, number of low words mirrored on dbg_words (1..DEPTH).

Ports:
- clk  in  1  system clock, all logic on posedge
- clr  in  1  reset, synchronous, active-high
- soft_clr  in  1  request memory clear without full reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  A_WIDTH  target word address
- req_wdata  in  D_WIDTH  write data
- rsp_valid  out  1  read data valid (1-cycle pulse per read)
- rsp_rdata  out  D_WIDTH  read data; holds last value when rsp_valid=0
- rsp_err  out  1  qualifies rsp_valid: read address was >= DEPTH
- wr_err  out  1  1-cycle pulse: accepted write had address >= DEPTH
- busy  out  1  clear sweep in progress
- dbg_words  out  N_DBG*D_WIDTH  words 0..N_DBG-1 concatenated, word 0 in LSBs

Behaviour:
- Reset: clr is synchronous and active-high. Sampled at posedge clk, it has priority over everything.
- Outputs after a clr edge: rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_err=0, req_ready=0, busy=1. The read pipeline is flushed and state goes to CLEAR with sweep pointer 0.
- FSM states: CLEAR and IDLE.
- CLEAR:
  - Writes 0 to word[ptr] each cycle and increments ptr.
  - After writing word DEPTH-1, goes to IDLE next cycle. The sweep takes exactly DEPTH cycles after clr deasserts.
  - busy=1 and req_ready=0 throughout; requests are not accepted (stalled, not dropped).
  - clr asserted mid-sweep restarts the sweep at ptr=0.
  - soft_clr is ignored while in CLEAR.
- IDLE:
  - busy=0. req_ready=1 unless soft_clr=1 this cycle.
  - A request is accepted when req_valid & req_ready.
  - soft_clr=1 in IDLE: no request is accepted that cycle and state goes to CLEAR with ptr=0.
  - Reads already in the pipeline still complete and return data captured before the sweep begins.
- Write, addr < DEPTH: word updated at the accepting edge. Visible to a read accepted on the next cycle.
- Write, addr >= DEPTH: memory unchanged; wr_err pulses the cycle after acceptance.
- Read accepted at edge N:
  - rsp_valid=1 in the cycle after edge N+RD_LAT-1. RD_LAT=1 gives data in the cycle right after acceptance.
  - With RD_LAT=2, one extra output register stage is added.
  - Fully pipelined: one read per cycle sustained, no bubbles.
- Read, addr >= DEPTH: rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Back-to-back write then read to the same address: the read returns the new data (no hazard; the write completes at its own edge).
- No backpressure on responses: the consumer must accept rsp every cycle it is valid.
- dbg_words: a register mirror of words 0..N_DBG-1, updated on the same edge as the memory. It is zero during and after any sweep.
- Out-of-range decode is needed only when DEPTH < 2**A_WIDTH; otherwise the compare is constant false.

Decomposition:
- Package ram_ctrl_pkg holds:
  - state enum (ST_CLEAR, ST_IDLE);
  - localparam RD_LAT_MAX=2;
  - a function computing the in-range flag.
- One sub-module, ram_ctrl_rdpipe: a D_WIDTH+1 wide shift pipeline of depth RD_LAT with a valid bit, synchronous clear on clr.
- Storage array, FSM and dbg mirror stay in ram_ctrl.

Test Plan:
- DEPTH=256: clr high 2 cycles then low -> busy=1, req_ready=0 for exactly 256 cycles, then busy=0. Every read of addr 0..255 returns 0x00.
- IDLE, D_WIDTH=8: write 0xA5 to 0x03, read 0x03 next cycle -> RD_LAT=1 gives rsp_valid one cycle later with 0xA5. dbg_words[31:24]=0xA5.
- RD_LAT=2: reads of 0x10,0x11,0x12 on consecutive cycles (preloaded 0x01,0x02,0x03) -> rsp_valid high 3 consecutive cycles starting 2 cycles after first accept, data 0x01,0x02,0x03.
- DEPTH=200: write 0x77 to addr 0xC8 -> wr_err pulse, no word changes. Read 0xC8 -> rsp_valid=1, rsp_err=1, rdata=0.
- soft_clr during streaming reads, then clr asserted at sweep cycle 50 -> in-flight reads return pre-clear data. req_ready=0 for 50 cycles, then a further 256 cycles after clr drops. All words then read 0.
- req_valid held high during CLEAR with write 0x5A to 0x00 -> not accepted until IDLE, then accepted on first IDLE cycle. Word 0 reads 0x5A.
